// File: rtl/temporizador_pkg.sv
// Shared types and limits for the BCD countdown timer: FSM state, BCD digit,
// digit limits and preset validation.
package temporizador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        RING  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    // Digit 0 is seconds units, digit 5 is hours tens.
    typedef bcd_t [5:0] digits_t;

    localparam int UNITS_MAX = 9;
    localparam int TENS_MAX  = 5;
    localparam int HOURS_MAX = 23;

    localparam logic [7:0] HOURS_MAX_BCD = {bcd_t'(HOURS_MAX / 10), bcd_t'(HOURS_MAX % 10)};

    function automatic int digit_max(input int idx);
        if (idx == 5)
            return HOURS_MAX / 10;
        else if (idx % 2 == 1)
            return TENS_MAX;
        else
            return UNITS_MAX;
    endfunction

    function automatic logic preset_valid(input digits_t d);
        return (d[0] <= bcd_t'(UNITS_MAX)) && (d[1] <= bcd_t'(TENS_MAX))
            && (d[2] <= bcd_t'(UNITS_MAX)) && (d[3] <= bcd_t'(TENS_MAX))
            && (d[4] <= bcd_t'(UNITS_MAX)) && ({d[5], d[4]} <= HOURS_MAX_BCD);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: decrements when borrow_in is set, wrapping
// 0 -> MAX and raising borrow_out to the next digit.
module bcd_down_digit
    import temporizador_pkg::*;
#(
    parameter int MAX = 9
) (
    input  bcd_t digit,
    input  logic borrow_in,
    output bcd_t digit_nx,
    output logic borrow_out
);

    always_comb begin
        digit_nx   = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == '0) begin
                digit_nx   = bcd_t'(MAX);
                borrow_out = 1'b1;
            end else begin
                digit_nx = digit - 1'b1;
            end
        end
    end

endmodule

// File: rtl/temporizador_bcd.sv
// HH:MM:SS BCD countdown timer with load/start/stop/ack control and ring alarm.
// Define TEMPORIZADOR_RING_TIMEOUT_EN to auto-clear the ring after RING_SECONDS.
module temporizador_bcd
    import temporizador_pkg::*;
#(
    parameter int CLK_HZ       = 100000000,
    parameter int RING_SECONDS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic       ack,
    input  logic [7:0] hor_in,
    input  logic [7:0] min_in,
    input  logic [7:0] seg_in,
    output logic [7:0] hor_out,
    output logic [7:0] min_out,
    output logic [7:0] seg_out,
    output logic       ring,
    output logic       running,
    output logic       load_err
);

`ifdef TEMPORIZADOR_RING_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int RW = (RING_SECONDS > 1) ? $clog2(RING_SECONDS + 1) : 1;

    state_t          state, state_nx;
    digits_t         cnt, cnt_nx, cnt_dec, preset;
    logic [PW-1:0]   presc, presc_nx;
    logic [RW-1:0]   rsec, rsec_nx;
    logic            tick, err_nx, underflow;

    assign preset = {hor_in, min_in, seg_in};

    // Borrow ripples seconds -> hours; a borrow out of the top digit means
    // the count was already zero.
    for (genvar i = 0; i < 6; i++) begin : g_dig
        logic bin, bout;
        if (i == 0) begin : g_first
            assign bin = 1'b1;
        end else begin : g_chain
            assign bin = g_dig[i-1].bout;
        end
        bcd_down_digit #(.MAX(digit_max(i))) u_digit (
            .digit      (cnt[i]),
            .borrow_in  (bin),
            .digit_nx   (cnt_dec[i]),
            .borrow_out (bout)
        );
    end
    assign underflow = g_dig[5].bout;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        presc_nx = presc;
        rsec_nx  = rsec;
        err_nx   = 1'b0;
        tick     = (presc == PW'(CLK_HZ - 1));

        if (state == RUN || (TIMEOUT_EN && state == RING))
            presc_nx = tick ? '0 : presc + 1'b1;

        if (state == RUN && tick && !underflow) begin
            cnt_nx = cnt_dec;
            if (cnt_dec == '0)
                state_nx = RING;
        end

        if (TIMEOUT_EN && state == RING && tick) begin
            rsec_nx = rsec + 1'b1;
            if (rsec == RW'(RING_SECONDS - 1))
                state_nx = IDLE;
        end

        // Commands override the free-running behaviour; load > stop > start > ack.
        if (load && state != RUN) begin
            if (preset_valid(preset)) begin
                cnt_nx   = preset;
                state_nx = IDLE;
                presc_nx = '0;
            end else begin
                err_nx = 1'b1;
            end
        end else if (stop && state == RUN) begin
            cnt_nx   = cnt;
            state_nx = PAUSE;
            presc_nx = '0;
        end else if (start && (state == IDLE || state == PAUSE) && cnt != '0) begin
            state_nx = RUN;
            presc_nx = '0;
        end else if (ack && state == RING) begin
            state_nx = IDLE;
            presc_nx = '0;
        end

        if (state_nx != RING)
            rsec_nx = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            presc    <= '0;
            rsec     <= '0;
            ring     <= 1'b0;
            running  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            presc    <= presc_nx;
            rsec     <= rsec_nx;
            ring     <= (state_nx == RING);
            running  <= (state_nx == RUN);
            load_err <= err_nx;
        end
    end

    assign hor_out = {cnt[5], cnt[4]};
    assign min_out = {cnt[3], cnt[2]};
    assign seg_out = {cnt[1], cnt[0]};

endmodule

// File: tb/tb_temporizador_bcd.sv
// Self-checking bench for temporizador_bcd: directed table, corner sequences
// and randomized commands against a seconds-level reference model.
module tb_temporizador_bcd;

    localparam int CLK_HZ       = 4;
    localparam int RING_SECONDS = 2;

`ifdef TEMPORIZADOR_RING_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, ack = 1'b0;
    logic [7:0] hor_in = '0, min_in = '0, seg_in = '0;
    logic [7:0] hor_out, min_out, seg_out;
    logic       ring, running, load_err;

    int vectors = 0;
    int miscompares = 0;

    temporizador_bcd #(.CLK_HZ(CLK_HZ), .RING_SECONDS(RING_SECONDS)) dut (
        .clk(clk), .reset(reset), .load(load), .start(start), .stop(stop), .ack(ack),
        .hor_in(hor_in), .min_in(min_in), .seg_in(seg_in),
        .hor_out(hor_out), .min_out(min_out), .seg_out(seg_out),
        .ring(ring), .running(running), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Reference model: count kept as total seconds, mode as a small integer.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_RING = 3;
    int m_mode = M_IDLE, m_secs = 0, m_presc = 0, m_rsec = 0;
    bit m_err = 1'b0;

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic bit ok_preset(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        return (h[3:0] <= 9) && (m[3:0] <= 9) && (s[3:0] <= 9)
            && (m[7:4] <= 5) && (s[7:4] <= 5) && (bcd2int(h) < 24);
    endfunction

    task automatic model_step();
        int  nmode, nsecs, npresc, nrsec;
        bit  tk;
        m_err = 1'b0;
        if (reset) begin
            m_mode = M_IDLE; m_secs = 0; m_presc = 0; m_rsec = 0;
            return;
        end
        tk = (m_presc == CLK_HZ - 1);
        nmode = m_mode; nsecs = m_secs; npresc = m_presc; nrsec = m_rsec;
        if (m_mode == M_RUN || (TO && m_mode == M_RING))
            npresc = tk ? 0 : m_presc + 1;
        if (m_mode == M_RUN && tk) begin
            nsecs = m_secs - 1;
            if (nsecs == 0) nmode = M_RING;
        end
        if (TO && m_mode == M_RING && tk) begin
            nrsec = m_rsec + 1;
            if (nrsec == RING_SECONDS) nmode = M_IDLE;
        end
        if (load && m_mode != M_RUN) begin
            if (ok_preset(hor_in, min_in, seg_in)) begin
                nsecs = bcd2int(hor_in) * 3600 + bcd2int(min_in) * 60 + bcd2int(seg_in);
                nmode = M_IDLE; npresc = 0;
            end else begin
                m_err = 1'b1;
            end
        end else if (stop && m_mode == M_RUN) begin
            nsecs = m_secs; nmode = M_PAUSE; npresc = 0;
        end else if (start && (m_mode == M_IDLE || m_mode == M_PAUSE) && m_secs != 0) begin
            nmode = M_RUN; npresc = 0;
        end else if (ack && m_mode == M_RING) begin
            nmode = M_IDLE; npresc = 0;
        end
        if (nmode != M_RING) nrsec = 0;
        m_mode = nmode; m_secs = nsecs; m_presc = npresc; m_rsec = nrsec;
    endtask

    // One clock: inputs already set, model advanced, outputs settle #1 after edge.
    task automatic cyc(input bit rs = 0, input bit ld = 0, input bit st = 0, input bit sp = 0,
                       input bit ak = 0, input logic [7:0] h = 8'h00, input logic [7:0] m = 8'h00,
                       input logic [7:0] s = 8'h00);
        reset = rs; load = ld; start = st; stop = sp; ack = ak;
        hor_in = h; min_in = m; seg_in = s;
        model_step();
        @(posedge clk);
        #1;
        reset = 0; load = 0; start = 0; stop = 0; ack = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_time(input string nm, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        chk(nm, {8'h00, hor_out, min_out, seg_out}, {8'h00, h, m, s});
    endtask

    typedef struct {
        bit         rs, ld, st, sp, ak;
        logic [7:0] h, m, s;
        logic [7:0] eh, em, es;
        bit         ering, erun, eerr;
        string      nm;
    } vec_t;

    vec_t tbl[$];
    int   n;

    initial begin
        tbl.push_back('{1,0,0,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0, "reset"});
        tbl.push_back('{0,1,0,0,0, 8'h01,8'h00,8'h00, 8'h01,8'h00,8'h00, 0,0,0, "load_01h"});
        tbl.push_back('{0,1,0,0,0, 8'h00,8'h00,8'h60, 8'h01,8'h00,8'h00, 0,0,1, "load_seg60"});
        tbl.push_back('{0,0,0,0,0, 8'h00,8'h00,8'h00, 8'h01,8'h00,8'h00, 0,0,0, "err_one_cycle"});
        tbl.push_back('{0,1,0,0,0, 8'h24,8'h00,8'h00, 8'h01,8'h00,8'h00, 0,0,1, "load_hor24"});
        tbl.push_back('{0,1,0,0,0, 8'h1A,8'h00,8'h00, 8'h01,8'h00,8'h00, 0,0,1, "load_hor1A"});
        tbl.push_back('{0,1,0,0,0, 8'h23,8'h59,8'h59, 8'h23,8'h59,8'h59, 0,0,0, "load_max"});
        tbl.push_back('{0,1,0,0,0, 8'h00,8'h5A,8'h00, 8'h23,8'h59,8'h59, 0,0,1, "load_min5A"});
        tbl.push_back('{0,1,0,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0, "load_zero"});
        tbl.push_back('{0,0,1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0, "start_zero"});
        tbl.push_back('{0,0,0,1,1, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 0,0,0, "stop_ack_idle"});
        tbl.push_back('{0,1,1,0,0, 8'h12,8'h34,8'h56, 8'h12,8'h34,8'h56, 0,0,0, "load_over_start"});
        tbl.push_back('{0,0,1,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h34,8'h56, 0,1,0, "start"});
        tbl.push_back('{0,1,0,0,0, 8'h00,8'h00,8'h01, 8'h12,8'h34,8'h56, 0,1,0, "load_in_run"});
        tbl.push_back('{0,0,1,1,0, 8'h00,8'h00,8'h00, 8'h12,8'h34,8'h56, 0,0,0, "stop_over_start"});
        tbl.push_back('{0,0,1,0,0, 8'h00,8'h00,8'h00, 8'h12,8'h34,8'h56, 0,1,0, "resume"});
        tbl.push_back('{1,1,1,0,0, 8'h05,8'h05,8'h05, 8'h00,8'h00,8'h00, 0,0,0, "reset_over_all"});

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            cyc(tbl[i].rs, tbl[i].ld, tbl[i].st, tbl[i].sp, tbl[i].ak, tbl[i].h, tbl[i].m, tbl[i].s);
            chk_time({tbl[i].nm, "_time"}, tbl[i].eh, tbl[i].em, tbl[i].es);
            chk({tbl[i].nm, "_ring"}, 32'(ring), 32'(tbl[i].ering));
            chk({tbl[i].nm, "_running"}, 32'(running), 32'(tbl[i].erun));
            chk({tbl[i].nm, "_load_err"}, 32'(load_err), 32'(tbl[i].eerr));
        end

        // 3 s countdown: zero and ring appear together 12 cycles after start.
        cyc(.ld(1), .s(8'h03));
        cyc(.st(1));
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (seg_out == 8'h00) begin n = k; break; end
        end
        chk("zero_latency", 32'(n), 32'd12);
        chk("ring_with_zero", 32'(ring), 32'd1);
        chk("running_at_zero", 32'(running), 32'd0);
        cyc(.ak(1));
        chk("ack_ring", 32'(ring), 32'd0);
        chk_time("ack_time", 8'h00, 8'h00, 8'h00);
        cyc(.st(1));
        chk("start_after_ack", 32'(running), 32'd0);

        // Full borrow chain across hours/minutes/seconds.
        cyc(.ld(1), .h(8'h01));
        cyc(.st(1));
        repeat (3) cyc();
        chk_time("before_tick", 8'h01, 8'h00, 8'h00);
        cyc();
        chk_time("borrow_chain", 8'h00, 8'h59, 8'h59);
        chk("borrow_running", 32'(running), 32'd1);

        // Pause/resume with an ignored load while running.
        cyc(.rs(1));
        cyc(.ld(1), .s(8'h10));
        cyc(.st(1));
        repeat (4) cyc();
        cyc(.ld(1), .s(8'h55));
        chk_time("load_ignored", 8'h00, 8'h00, 8'h09);
        chk("load_ignored_err", 32'(load_err), 32'd0);
        repeat (3) cyc();
        chk_time("two_ticks", 8'h00, 8'h00, 8'h08);
        cyc(.sp(1));
        chk("paused_running", 32'(running), 32'd0);
        repeat (20) cyc();
        chk_time("paused_held", 8'h00, 8'h00, 8'h08);
        cyc(.st(1));
        chk("resumed", 32'(running), 32'd1);
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            cyc();
            if (ring) begin n = k; break; end
        end
        chk("resume_to_zero", 32'(n), 32'd32);

        // Reset in RING and in RUN.
        cyc(.rs(1));
        chk("reset_ring", 32'({ring, running, load_err}), 32'd0);
        chk_time("reset_ring_time", 8'h00, 8'h00, 8'h00);
        cyc(.ld(1), .s(8'h05));
        cyc(.st(1));
        repeat (6) cyc();
        cyc(.rs(1));
        chk("reset_run", 32'({ring, running, load_err}), 32'd0);
        chk_time("reset_run_time", 8'h00, 8'h00, 8'h00);
        cyc(.st(1));
        repeat (8) cyc();
        chk("no_residual", 32'({hor_out, min_out, seg_out, ring, running}), 32'd0);

        // Ring persistence / auto-clear.
        cyc(.ld(1), .s(8'h01));
        cyc(.st(1));
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (ring) begin n = k; break; end
        end
        chk("ring_1s", 32'(n), 32'd4);
        if (TO) begin
            repeat (7) cyc();
            chk("timeout_still", 32'(ring), 32'd1);
            cyc();
            chk("timeout_clear", 32'(ring), 32'd0);
        end else begin
            repeat (100) cyc();
            chk("ring_holds", 32'(ring), 32'd1);
            cyc(.ak(1));
        end

        // Randomized commands against the model.
        for (int k = 0; k < 3000; k++) begin
            bit rs, ld, st, sp, ak;
            logic [7:0] h, m, s;
            int sel;
            rs = ($urandom_range(199) == 0);
            ld = ($urandom_range(24) == 0);
            st = ($urandom_range(9) == 0);
            sp = ($urandom_range(39) == 0);
            ak = ($urandom_range(14) == 0);
            sel = $urandom_range(3);
            if (sel < 2) begin
                h = 8'h00; m = 8'h00; s = int2bcd($urandom_range(20));
            end else if (sel == 2) begin
                h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
            end else begin
                h = int2bcd($urandom_range(23)); m = int2bcd($urandom_range(59));
                s = int2bcd($urandom_range(59));
            end
            cyc(rs, ld, st, sp, ak, h, m, s);
            chk_time("rand_time", int2bcd(m_secs / 3600), int2bcd((m_secs / 60) % 60), int2bcd(m_secs % 60));
            chk("rand_flags", 32'({ring, running, load_err}),
                32'({m_mode == M_RING, m_mode == M_RUN, m_err}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/temporizador_bcd.md
TEMPORIZADOR_BCD -- requirements
Module: temporizador_bcd

Interface
REQ-001 Parameter CLK_HZ, default 100000000, clk cycles per 1 s tick.
REQ-002 Parameter RING_SECONDS, default 10, ring auto-clear duration in seconds; used only under REQ-030.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load  input  1  one-cycle pulse; captures hor_in/min_in/seg_in.
REQ-006 start  input  1  one-cycle pulse; begins or resumes countdown.
REQ-007 stop  input  1  one-cycle pulse; pauses countdown.
REQ-008 ack  input  1  one-cycle pulse; silences ring.
REQ-009 hor_in, min_in, seg_in  input  8 each  packed BCD preset, tens in [7:4], units in [3:0].
REQ-010 hor_out, min_out, seg_out  output  8 each  packed BCD count; feeds datos10/datos9/datos8 of the display interface.
REQ-011 ring  output  1  alarm; drives the display ring input.
REQ-012 running  output  1  high in RUN only.
REQ-013 load_err  output  1  one-cycle pulse on rejected load.

Function
REQ-014 FSM states IDLE, RUN, PAUSE, RING; all outputs registered.
REQ-015 Command priority when coincident: load > stop > start > ack.
REQ-016 load accepted in IDLE, PAUSE, RING: next cycle outputs = preset, state -> IDLE, ring = 0; ignored in RUN (no load_err).
REQ-017 Preset valid iff every units digit <= 9, seg/min tens <= 5, hours <= 23; invalid preset leaves count unchanged, load_err = 1 for exactly the next cycle.
REQ-018 start in IDLE or PAUSE with count != 00:00:00: state -> RUN, prescaler cleared to 0; start with count 00:00:00 is ignored.
REQ-019 stop in RUN: state -> PAUSE, count held, prescaler cleared; stop elsewhere ignored.
REQ-020 Prescaler counts 0..CLK_HZ-1 in RUN (and in RING under REQ-030); tick asserted when it reaches CLK_HZ-1, then wraps to 0.
REQ-021 First decrement occurs exactly CLK_HZ cycles after the accepted start; outputs update on the cycle after tick.
REQ-022 Decrement with BCD borrow: seconds units 0 -> 9 with borrow, seconds tens 0 -> 5 with borrow, same for minutes; hours decremented with BCD borrow, never below 00.
REQ-023 When a decrement yields 00:00:00: state -> RING and ring = 1 in the same cycle the zero count appears.
REQ-024 ack in RING: state -> IDLE, ring = 0 next cycle, count stays 00:00:00; ack elsewhere ignored.
REQ-025 Outputs never hold non-BCD digit values.

Reset
REQ-026 On reset: state IDLE, count 00:00:00, prescaler 0, ring 0, running 0, load_err 0, all on the next clk edge.
REQ-027 reset overrides every command and applies mid-RUN or mid-RING without residual ring or tick.

Configuration
REQ-028 Macro TEMPORIZADOR_RING_TIMEOUT_EN selects ring auto-clear.
REQ-029 Without it: ring stays high until ack, load, or reset.
REQ-030 With it: prescaler runs in RING; after RING_SECONDS ticks, ring -> 0 and state -> IDLE; ack still clears earlier.

Structure
REQ-031 Package temporizador_pkg holds the state enum, BCD digit type, and limit constants (9, 5, 23).
REQ-032 Sub-module bcd_down_digit: one digit, parameterised max value, borrow-in/borrow-out; six instances chain seconds -> minutes -> hours.

Verification
REQ-033 CLK_HZ=4: load 00:00:03, start -> 00:00:00 at cycle 12 after start, ring = 1 same cycle; ack -> ring 0, IDLE.
REQ-034 Load 01:00:00, start, one tick -> hor_out 8'h00, min_out 8'h59, seg_out 8'h59.
REQ-035 load with seg_in 8'h60 or hor_in 8'h24 -> load_err one cycle, outputs unchanged.
REQ-036 Run 00:00:10, stop after 2 ticks -> 00:00:08 held, running 0; load during RUN ignored; start resumes, zero 8 ticks later.
REQ-037 Reset asserted in RUN and in RING -> all outputs zero, IDLE next cycle; start with 00:00:00 ignored.
REQ-038 With TEMPORIZADOR_RING_TIMEOUT_EN, RING_SECONDS=2, CLK_HZ=4 -> ring clears 8 cycles after assertion; without macro ring still high after 100 cycles.
